// File: rtl/maxnet_stream_loader_pkg.sv
// Shared definitions for the Maxnet stream loader: default sizes, FSM state
// encodings (common with the Maxnet controller) and small sizing helpers.
package maxnet_stream_loader_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_N      = 4;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Index width for n elements, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxnet_stream_loader_x_vector_buffer.sv
// N x DATA_W register file holding the X vector; one element written per
// cycle by index, all elements cleared by the asynchronous reset.
module x_vector_buffer
    import maxnet_stream_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int IDX_W  = cnt_width(DEF_N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [N*DATA_W-1:0] x_vec
);

    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [DATA_W-1:0] elem_r;

        // Element register: load when this index is addressed, otherwise hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                elem_r <= {DATA_W{1'b0}};
            end else if (we && (idx == IDX_W'(i))) begin
                elem_r <= wdata;
            end else begin
                elem_r <= elem_r;
            end
        end

        assign x_vec[DATA_W*i +: DATA_W] = elem_r;
    end

endmodule

// File: rtl/maxnet_stream_loader.sv
// Maxnet stream loader: gathers N input words into the X vector, kicks the
// Maxnet controller, and returns its winner (or a timeout flag) downstream.
module maxnet_stream_loader
    import maxnet_stream_loader_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N       = DEF_N,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N*DATA_W-1:0] x_vec,
    output logic                start,
    input  logic                done_in,
    input  logic [DATA_W-1:0]   res_in,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err
);

    localparam int CNT_W = cnt_width(N);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e             state_r;
    state_e             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [TMR_W-1:0]   timer_r;
    logic               buf_we_s;
    logic               last_word_s;
    logic               timer_exp_s;
    logic               cap_res_s;
    logic               cap_to_s;
    logic               drain_ack_s;
    logic               start_r;
    logic               out_valid_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               err_r;

    assign last_word_s = (cnt_r == CNT_W'(N - 1));
    assign timer_exp_s = (timer_r == TMR_W'(TIMEOUT));

    x_vector_buffer #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX_W  (CNT_W)
    ) u_x_buf (
        .clk    (clk),
        .rst    (rst),
        .we     (buf_we_s),
        .idx    (cnt_r),
        .wdata  (in_data),
        .x_vec  (x_vec)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (buf_we_s && last_word_s) begin
                    state_next_s = ST_LAUNCH;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_LAUNCH: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (cap_res_s || cap_to_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (drain_ack_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // Per-state strobes; done_in outranks the timeout, and is ignored in LAUNCH.
    always_comb begin
        in_ready    = 1'b0;
        buf_we_s    = 1'b0;
        cap_res_s   = 1'b0;
        cap_to_s    = 1'b0;
        drain_ack_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                in_ready = 1'b1;
                buf_we_s = in_valid;
            end
            ST_WAIT: begin
                cap_res_s = done_in;
                cap_to_s  = !done_in && timer_exp_s;
            end
            ST_DRAIN:  drain_ack_s = out_ready;
            ST_LAUNCH: in_ready = 1'b0;
            default:   in_ready = 1'b0;
        endcase
    end

    // Word counter and WAIT timer (saturates at TIMEOUT).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            timer_r <= {TMR_W{1'b0}};
        end else begin
            if (buf_we_s) begin
                cnt_r <= last_word_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ST_LAUNCH) begin
                timer_r <= {TMR_W{1'b0}};
            end else if ((state_r == ST_WAIT) && !timer_exp_s) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Registered outputs: start pulse and the result/handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            start_r <= (state_next_s == ST_LAUNCH);
            if (cap_res_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= res_in;
                err_r       <= 1'b0;
            end else if (cap_to_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= {DATA_W{1'b0}};
                err_r       <= 1'b1;
            end else if (drain_ack_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign start     = start_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err       = err_r;

endmodule

// File: tb/tb_maxnet_stream_loader.sv
// Directed self-checking bench for maxnet_stream_loader (DATA_W=32, N=4, TIMEOUT=8).
module tb_maxnet_stream_loader;

    logic         clk;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] x_vec;
    logic         start;
    logic         done_in;
    logic [31:0]  res_in;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    maxnet_stream_loader #(.DATA_W(32), .N(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x_vec(x_vec), .start(start), .done_in(done_in),
        .res_in(res_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_word: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] a, b, c, d);
        send_word(a); send_word(b); send_word(c); send_word(d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, start, out_valid, err} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 1000", {in_ready, start, out_valid, err});
        end
        total++;
        if (x_vec !== 128'd0 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: x_vec=%h out_data=%h required 0", x_vec, out_data);
        end
    endtask

    task automatic test_back_to_back();
        start_cnt = 0;
        send_vec(32'd10, 32'd20, 32'd30, 32'd40);
        total++;
        if (start !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_launch: start=%b in_ready=%b required 1 0", start, in_ready);
        end
        total++;
        if (x_vec !== {32'd40, 32'd30, 32'd20, 32'd10}) begin
            bad++;
            $display("FAIL b2b_xvec: got %h required %h", x_vec, {32'd40, 32'd30, 32'd20, 32'd10});
        end
        tick();
        total++;
        if (start !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start_pulse: start=%b required 0", start);
        end
        tick();
        tick();
        done_in = 1'b1;
        res_in  = 32'd40;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_early_valid: out_valid=%b required 0", out_valid);
        end
        tick();
        done_in = 1'b0;
        res_in  = 32'd0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd40 || err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_result: valid=%b data=%0d err=%b required 1 40 0", out_valid, out_data, err);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || start_cnt != 1) begin
            bad++;
            $display("FAIL b2b_ack: valid=%b in_ready=%b starts=%0d required 0 1 1", out_valid, in_ready, start_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w [4];
        w[0] = 32'd10; w[1] = 32'd20; w[2] = 32'd30; w[3] = 32'd40;
        start_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            send_word(w[k]);
            if (k < 3) begin
                tick();
                tick();
                total++;
                if (start_cnt != 0 || in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL gaps_early_start: starts=%0d in_ready=%b required 0 1", start_cnt, in_ready);
                end
            end
        end
        total++;
        if (start !== 1'b1 || x_vec !== {32'd40, 32'd30, 32'd20, 32'd10}) begin
            bad++;
            $display("FAIL gaps_launch: start=%b x_vec=%h", start, x_vec);
        end
        tick();
        done_in = 1'b1;
        res_in  = 32'd7;
        tick();
        done_in = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'd7) begin
            bad++;
            $display("FAIL gaps_result: valid=%b data=%0d required 1 7", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        send_vec(32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: out_valid=%b required 0 at WAIT cycle 9", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || err !== 1'b1 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL timeout_flag: valid=%b err=%b data=%h required 1 1 0", out_valid, err, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ack: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        send_vec(32'd5, 32'd6, 32'd7, 32'd8);
        tick();
        done_in = 1'b1;
        res_in  = 32'h1234;
        tick();
        done_in  = 1'b0;
        res_in   = 32'h9999;
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h1234 || err !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: valid=%b data=%h err=%b in_ready=%b required 1 1234 0 0",
                         out_valid, out_data, err, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ack: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        total++;
        if (x_vec !== {32'd8, 32'd7, 32'd6, 32'd5}) begin
            bad++;
            $display("FAIL bp_ignored_words: x_vec=%h required %h", x_vec, {32'd8, 32'd7, 32'd6, 32'd5});
        end
    endtask

    task automatic test_mid_reset();
        send_word(32'd11);
        send_word(32'd22);
        rst = 1'b1;
        #1;
        total++;
        if (x_vec !== 128'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || start !== 1'b0) begin
            bad++;
            $display("FAIL rst_fill: x_vec=%h in_ready=%b valid=%b start=%b", x_vec, in_ready, out_valid, start);
        end
        tick();
        rst = 1'b0;
        start_cnt = 0;
        send_vec(32'd5, 32'd6, 32'd7, 32'd8);
        total++;
        if (x_vec !== {32'd8, 32'd7, 32'd6, 32'd5} || start !== 1'b1) begin
            bad++;
            $display("FAIL rst_fresh_vec: x_vec=%h start=%b", x_vec, start);
        end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (x_vec !== 128'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait: x_vec=%h in_ready=%b valid=%b data=%h err=%b",
                     x_vec, in_ready, out_valid, out_data, err);
        end
        tick();
        rst = 1'b0;
        start_cnt = 0;
        send_vec(32'd1, 32'd2, 32'd3, 32'd4);
        tick();
        total++;
        if (x_vec !== {32'd4, 32'd3, 32'd2, 32'd1} || start_cnt != 1) begin
            bad++;
            $display("FAIL rst_second_vec: x_vec=%h starts=%0d required 1", x_vec, start_cnt);
        end
        done_in = 1'b1;
        res_in  = 32'd3;
        tick();
        done_in   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_launch_done();
        send_vec(32'd9, 32'd8, 32'd7, 32'd6);
        done_in = 1'b1;
        res_in  = 32'd123;
        tick();
        done_in = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL launch_done_ignored: out_valid=%b required 0", out_valid);
        end
        tick();
        tick();
        done_in = 1'b1;
        res_in  = 32'hFFFF_FFFB;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL launch_done_wait: out_valid=%b required 0", out_valid);
        end
        tick();
        done_in = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFB || err !== 1'b0) begin
            bad++;
            $display("FAIL launch_done_result: valid=%b data=%h err=%b required 1 fffffffb 0",
                     out_valid, out_data, err);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = 32'd0; in_valid = 1'b0;
        done_in = 1'b0; res_in = 32'd0; out_ready = 1'b0;
        #2;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_timeout();
        test_backpressure();
        test_mid_reset();
        test_launch_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
